// File: rtl/serial_display_rx_pkg.sv
// Shared definitions for the serial display link receiver: FSM states,
// default frame widths and the bit-counter width helper.
package serial_display_rx_pkg;

    localparam int SEG_W = 64;   // 8 digits x 8 segments
    localparam int LED_W = 16;   // LED bank

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } rx_state_e;

    // Counter must hold 0..DATA_W+1 (DATA_W+1 marks an overlong frame).
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 2);
    endfunction

endpackage

// File: rtl/serial_display_rx_if.sv
// Serial display link bundle: the three serial lines from the transmitter and
// the received-frame outputs, plus the FSM state for observation.
interface serial_display_rx_if #(
    parameter int DATA_W = serial_display_rx_pkg::SEG_W
);
    import serial_display_rx_pkg::*;

    localparam int CW = cnt_width(DATA_W);

    // Serial lines are asynchronous to clk; no handshake. valid is a one-cycle
    // pulse, data/frame_err hold until the next frame end.
    logic              ser_clk;
    logic              ser_do;
    logic              ser_pen;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic [CW-1:0]     bit_cnt;
    rx_state_e         state;

    modport master (
        output ser_clk, ser_do, ser_pen,
        input  data, valid, frame_err, bit_cnt, state
    );

    modport slave (
        input  ser_clk, ser_do, ser_pen,
        output data, valid, frame_err, bit_cnt, state
    );

endinterface

// File: rtl/serial_display_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line followed by a previous-value
// flop; rise flags a synchronised 0->1 transition for exactly one cycle.
module serial_display_rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;

endmodule

// File: rtl/serial_display_rx.sv
// Receive end of the 74HC595-style display link: oversamples CLK/DO/PEN,
// shifts frames MSB-first and presents each latched word with a valid pulse.
module serial_display_rx
    import serial_display_rx_pkg::*;
#(
    parameter int DATA_W      = SEG_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    serial_display_rx_if.slave  bus
);

    localparam int CW = cnt_width(DATA_W);
    localparam int AW = $clog2(SYNC_STAGES + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_W + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(SYNC_STAGES);

    logic clk_sync_unused;
    logic clk_rise;
    logic do_sync;
    logic do_rise_unused;
    logic pen_sync_unused;
    logic pen_rise;

    serial_display_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk  (clk),
        .rstn (rstn),
        .d    (bus.ser_clk),
        .sync (clk_sync_unused),
        .rise (clk_rise)
    );

    serial_display_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_do (
        .clk  (clk),
        .rstn (rstn),
        .d    (bus.ser_do),
        .sync (do_sync),
        .rise (do_rise_unused)
    );

    serial_display_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pen (
        .clk  (clk),
        .rstn (rstn),
        .d    (bus.ser_pen),
        .sync (pen_sync_unused),
        .rise (pen_rise)
    );

    rx_state_e         state_q, state_d;
    logic [AW-1:0]     arm_q, arm_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_ARM;
            arm_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            // Let the synchronisers fill so a line high at reset release
            // never looks like a rising edge.
            ST_ARM: begin
                if (arm_q == ARM_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    arm_d = arm_q + AW'(1);
                end
            end

            // A clock edge coinciding with the strobe is shifted in first, so
            // the latched word includes it.
            ST_IDLE, ST_SHIFT: begin
                if (clk_rise) begin
                    shreg_d = {shreg_q[DATA_W-2:0], do_sync};
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    state_d = ST_SHIFT;
                end
                if (pen_rise) begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                err_d   = (cnt_q != CNT_FULL);
                shreg_d = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
                // An edge arriving now opens the next frame.
                if (clk_rise) begin
                    shreg_d = {{(DATA_W-1){1'b0}}, do_sync};
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end

            default: state_d = ST_ARM;
        endcase
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = err_q;
    assign bus.bit_cnt   = cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_serial_display_rx.sv
// Bench for serial_display_rx: a 64-bit and a 16-bit receiver share one serial
// link; frames are checked against a bit-queue model and a constant table.
module tb_serial_display_rx;
    import serial_display_rx_pkg::*;

    localparam int SYNC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic ser_clk, ser_do, ser_pen;

    serial_display_rx_if #(.DATA_W(64)) if64 ();
    serial_display_rx_if #(.DATA_W(16)) if16 ();

    assign if64.ser_clk = ser_clk;
    assign if64.ser_do  = ser_do;
    assign if64.ser_pen = ser_pen;
    assign if16.ser_clk = ser_clk;
    assign if16.ser_do  = ser_do;
    assign if16.ser_pen = ser_pen;

    serial_display_rx #(.DATA_W(64), .SYNC_STAGES(SYNC)) dut64 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if64)
    );

    serial_display_rx #(.DATA_W(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if16)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    int v64_cnt = 0;
    int v16_cnt = 0;
    logic [64:0] exp64_q[$];
    logic [16:0] exp16_q[$];
    logic        frame_bits[$];
    logic [64:0] e64;
    logic [16:0] e16;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the word is simply the last w bits sent, MSB first.
    function automatic void model(input int w, output logic [63:0] d, output logic e);
        d = '0;
        foreach (frame_bits[i]) d = {d[62:0], frame_bits[i]};
        if (w < 64) d = d & ((64'd1 << w) - 64'd1);
        e = (frame_bits.size() != w);
    endfunction

    task automatic push_model();
        logic [63:0] d;
        logic        e;
        model(64, d, e);
        exp64_q.push_back({e, d});
        model(16, d, e);
        exp16_q.push_back({e, d[15:0]});
        frame_bits.delete();
    endtask

    always @(negedge clk) begin
        if (if64.valid === 1'b1) begin
            v64_cnt++;
            if (exp64_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL valid64_unexpected: got data %h err %b", if64.data, if64.frame_err);
            end else begin
                e64 = exp64_q.pop_front();
                check("data64", if64.data, e64[63:0]);
                check("frame_err64", 64'(if64.frame_err), 64'(e64[64]));
            end
        end
        if (if16.valid === 1'b1) begin
            v16_cnt++;
            if (exp16_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL valid16_unexpected: got data %h err %b", if16.data, if16.frame_err);
            end else begin
                e16 = exp16_q.pop_front();
                check("data16", 64'(if16.data), 64'(e16[15:0]));
                check("frame_err16", 64'(if16.frame_err), 64'(e16[16]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        ser_do = b;
        repeat (4) @(negedge clk);
        ser_clk = 1'b1;
        frame_bits.push_back(b);
        repeat (4) @(negedge clk);
        ser_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(i < 64 ? word[i] : 1'b1);
    endtask

    task automatic check_cnt(input int n);
        check("bit_cnt64", 64'(if64.bit_cnt), 64'(n > 65 ? 65 : n));
        check("bit_cnt16", 64'(if16.bit_cnt), 64'(n > 17 ? 17 : n));
    endtask

    // Raise pen (optionally with the last clock edge) and time valid.
    task automatic pen_strobe(input bit with_clk, input bit use_model);
        int lat;
        if (with_clk) frame_bits.push_back(ser_do);
        if (use_model) push_model();
        ser_pen = 1'b1;
        if (with_clk) ser_clk = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (if64.valid === 1'b1 && lat == 0) lat = i;
        end
        check("pen_latency", 64'(lat), 64'(SYNC + 2));
        ser_pen = 1'b0;
        ser_clk = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt(0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          nbits;
        logic [63:0] word;
        logic [63:0] exp64;
        logic        err64;
        logic [15:0] exp16;
        logic        err16;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [63:0] w;
        logic        b;
        int          n, vb;

        tbl[0] = '{64, 64'hF0E1_D2C3_B4A5_9687, 64'hF0E1_D2C3_B4A5_9687, 1'b0, 16'h9687, 1'b1};
        tbl[1] = '{8,  64'h0000_0000_0000_00A5, 64'h0000_0000_0000_00A5, 1'b1, 16'h00A5, 1'b1};
        tbl[2] = '{64, 64'hFFFF_0000_AAAA_5555, 64'hFFFF_0000_AAAA_5555, 1'b0, 16'h5555, 1'b1};
        tbl[3] = '{16, 64'h0000_0000_0000_BEEF, 64'h0000_0000_0000_BEEF, 1'b1, 16'hBEEF, 1'b0};
        tbl[4] = '{4,  64'h0000_0000_0000_000B, 64'h0000_0000_0000_000B, 1'b1, 16'h000B, 1'b1};
        tbl[5] = '{0,  64'h0,                   64'h0,                   1'b1, 16'h0000, 1'b1};
        tbl[6] = '{66, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 16'hCDEF, 1'b1};

        // Reset with ser_clk held high: ARM must swallow the apparent edge.
        rstn = 1'b0; ser_clk = 1'b1; ser_do = 1'b0; ser_pen = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data64", if64.data, 64'h0);
        check("rst_valid64", 64'(if64.valid), 64'h0);
        check("rst_err64", 64'(if64.frame_err), 64'h0);
        check("rst_state64", 64'(if64.state), 64'(ST_ARM));
        check_cnt(0);
        rstn = 1'b1;
        @(negedge clk);
        check("arm_state64", 64'(if64.state), 64'(ST_ARM));
        check_cnt(0);
        repeat (10) @(negedge clk);
        check("idle_state64", 64'(if64.state), 64'(ST_IDLE));
        check("idle_data64", if64.data, 64'h0);
        check_cnt(0);
        ser_clk = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames.
        foreach (tbl[k]) begin
            send_bits(tbl[k].word, tbl[k].nbits);
            check_cnt(tbl[k].nbits);
            exp64_q.push_back({tbl[k].err64, tbl[k].exp64});
            exp16_q.push_back({tbl[k].err16, tbl[k].exp16});
            frame_bits.delete();
            pen_strobe(1'b0, 1'b0);
        end

        // Last clock edge and pen on the same cycle after 63 bits.
        w = {$urandom, $urandom};
        send_bits(w, 63);
        check_cnt(63);
        ser_do = $urandom_range(0, 1);
        repeat (4) @(negedge clk);
        pen_strobe(1'b1, 1'b1);

        // Clock edge landing in the LATCH cycle opens the next frame.
        w = {$urandom, $urandom};
        send_bits(w, 64);
        b = $urandom_range(0, 1);
        ser_do = b;
        push_model();
        ser_pen = 1'b1;
        @(negedge clk);
        ser_clk = 1'b1;
        frame_bits.push_back(b);
        repeat (6) @(negedge clk);
        ser_clk = 1'b0;
        ser_pen = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt(1);
        check("latch_edge_state64", 64'(if64.state), 64'(ST_SHIFT));
        send_bits({$urandom, $urandom}, 63);
        pen_strobe(1'b0, 1'b1);

        // Reset mid-frame discards the partial frame.
        send_bits({$urandom, $urandom}, 30);
        rstn = 1'b0;
        #1;
        check("midrst_data64", if64.data, 64'h0);
        check("midrst_data16", 64'(if16.data), 64'h0);
        check("midrst_err64", 64'(if64.frame_err), 64'h0);
        check("midrst_valid64", 64'(if64.valid), 64'h0);
        check_cnt(0);
        frame_bits.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        vb = v64_cnt;
        send_bits({$urandom, $urandom}, 64);
        pen_strobe(1'b0, 1'b1);
        check("midrst_valid_count", 64'(v64_cnt - vb), 64'd1);

        // Randomised frames against the model.
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(0, 70);
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                send_bits({$urandom, $urandom}, n - 1);
                ser_do = $urandom_range(0, 1);
                repeat (4) @(negedge clk);
                pen_strobe(1'b1, 1'b1);
            end else begin
                send_bits({$urandom, $urandom}, n);
                check_cnt(n);
                pen_strobe(1'b0, 1'b1);
            end
        end

        repeat (10) @(negedge clk);
        check("pending64", 64'(exp64_q.size()), 64'h0);
        check("pending16", 64'(exp16_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
